// File: rtl/register_bank.sv
// General-purpose register file: two combinational read ports with optional
// write bypass, one synchronous write port, and a valid/ready serial dump port.
module register_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_wenable,
  input  logic [ADDR_W-1:0] i_addr_wr,
  input  logic [DATA_W-1:0] i_data_wr,
  input  logic [ADDR_W-1:0] i_addr_rs,
  input  logic [ADDR_W-1:0] i_addr_rt,
  output logic [DATA_W-1:0] o_data_rs,
  output logic [DATA_W-1:0] o_data_rt,
  input  logic              i_dump_start,
  input  logic              i_dump_ready,
  output logic              o_dump_valid,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, DUMP, DONE} dump_state_t;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_live;
  dump_state_t       state, next_state;
  logic [ADDR_W-1:0] ptr, next_ptr;

  // A write to the hard-wired zero register neither updates storage nor bypasses.
  assign wr_live = i_wenable && !(ZERO_REG && (i_addr_wr == '0));

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[i_addr_wr] <= i_data_wr;
    end
  end

  always_comb begin
    o_data_rs = regs[i_addr_rs];
    o_data_rt = regs[i_addr_rt];
    if (ZERO_REG && (i_addr_rs == '0)) o_data_rs = '0;
    if (ZERO_REG && (i_addr_rt == '0)) o_data_rt = '0;
    if (BYPASS && wr_live && (i_addr_rs == i_addr_wr)) o_data_rs = i_data_wr;
    if (BYPASS && wr_live && (i_addr_rt == i_addr_wr)) o_data_rt = i_data_wr;
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  always_comb begin
    next_state   = state;
    next_ptr     = ptr;
    o_dump_valid = 1'b0;
    o_dump_addr  = '0;
    o_dump_data  = '0;
    o_dump_done  = 1'b0;
    case (state)
      IDLE: begin
        if (i_dump_start) begin
          next_state = DUMP;
          next_ptr   = '0;
        end
      end
      DUMP: begin
        o_dump_valid = 1'b1;
        o_dump_addr  = ptr;
        // Dump reads storage directly; in-flight writes land on the next edge.
        o_dump_data  = (ZERO_REG && (ptr == '0)) ? '0 : regs[ptr];
        if (i_dump_ready) begin
          if (&ptr) next_state = DONE;
          else      next_ptr   = ptr + 1'b1;
        end
      end
      DONE: begin
        o_dump_done = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: stimulus pushes expected values, a
// negedge monitor pops and compares read/status samples and dump handshakes.
module tb_register_bank;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n, wen, start, ready;
  logic [4:0]  awr, ars, art;
  logic [31:0] dwr;
  logic [31:0] data_rs, data_rt, nb_rs, nb_rt, dump_data, nb_dump_data;
  logic [4:0]  dump_addr, nb_dump_addr;
  logic        dump_valid, dump_done, nb_dump_valid, nb_dump_done;

  always #5 clk = ~clk;

  register_bank #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .i_reset_n(rst_n), .i_wenable(wen), .i_addr_wr(awr), .i_data_wr(dwr),
    .i_addr_rs(ars), .i_addr_rt(art), .o_data_rs(data_rs), .o_data_rt(data_rt),
    .i_dump_start(start), .i_dump_ready(ready), .o_dump_valid(dump_valid),
    .o_dump_addr(dump_addr), .o_dump_data(dump_data), .o_dump_done(dump_done)
  );

  register_bank #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .i_reset_n(rst_n), .i_wenable(wen), .i_addr_wr(awr), .i_data_wr(dwr),
    .i_addr_rs(ars), .i_addr_rt(art), .o_data_rs(nb_rs), .o_data_rt(nb_rt),
    .i_dump_start(start), .i_dump_ready(ready), .o_dump_valid(nb_dump_valid),
    .o_dump_addr(nb_dump_addr), .o_dump_data(nb_dump_data), .o_dump_done(nb_dump_done)
  );

  typedef struct {
    string       name;
    logic [31:0] rs, rt, nb;
    logic        valid;
    logic [4:0]  daddr;
    logic        done;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } dexp_t;

  exp_t  read_q[$];
  dexp_t dump_q[$];
  exp_t  cur_e;
  dexp_t cur_d;
  logic  sample_req;
  int    total = 0;
  int    bad   = 0;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] aw,
                               input logic [31:0] dw, input logic [4:0] rs,
                               input logic [4:0] rt, input logic st, input logic rdy);
    @(posedge clk);
    #1;
    sample_req = 1'b0;
    rst_n = rst; wen = we; awr = aw; dwr = dw;
    ars = rs; art = rt; start = st; ready = rdy;
  endtask

  task automatic pushExp(input string nm, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] nb, input logic v, input logic [4:0] a,
                         input logic d);
    exp_t e;
    e.name = nm; e.rs = rs; e.rt = rt; e.nb = nb;
    e.valid = v; e.daddr = a; e.done = d;
    read_q.push_back(e);
    sample_req = 1'b1;
  endtask

  task automatic pushDump(input int a, input logic [31:0] d);
    dexp_t x;
    x.addr = 5'(a);
    x.data = d;
    dump_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sample_req) begin
      if (read_q.size() == 0) begin
        checkOutput("read_q_underflow", 32'd1, 32'd0);
      end else begin
        cur_e = read_q.pop_front();
        checkOutput({cur_e.name, ".rs"}, data_rs, cur_e.rs);
        checkOutput({cur_e.name, ".rt"}, data_rt, cur_e.rt);
        checkOutput({cur_e.name, ".nb_rs"}, nb_rs, cur_e.nb);
        checkOutput({cur_e.name, ".valid"}, {31'b0, dump_valid}, {31'b0, cur_e.valid});
        checkOutput({cur_e.name, ".daddr"}, {27'b0, dump_addr}, {27'b0, cur_e.daddr});
        checkOutput({cur_e.name, ".done"}, {31'b0, dump_done}, {31'b0, cur_e.done});
        if (!cur_e.valid) checkOutput({cur_e.name, ".ddata"}, dump_data, 32'd0);
      end
    end
    if (dump_valid && ready) begin
      if (dump_q.size() == 0) begin
        checkOutput("dump_unexpected", {27'b0, dump_addr}, 32'hFFFF_FFFF);
      end else begin
        cur_d = dump_q.pop_front();
        checkOutput("dump.addr", {27'b0, dump_addr}, {27'b0, cur_d.addr});
        checkOutput("dump.data", dump_data, cur_d.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1; wen = 1'b0; awr = '0; dwr = '0; ars = '0; art = '0;
    start = 1'b0; ready = 1'b0; sample_req = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held with start high: reset must win.
    applyStimulus(0, 0, 0, 0, 3, 4, 1, 1); pushExp("rst_hold", 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0); pushExp("rst_start", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, 0, 0, 5'(i), 5'(DEPTH - 1 - i), 0, 0);
      pushExp("reset_read", 0, 0, 0, 0, 0, 0);
    end

    // Same-cycle bypass on each port.
    applyStimulus(1, 1, 5, 32'hDEADBEEF, 5, 6, 0, 0);
    pushExp("bypass_rs", 32'hDEADBEEF, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 5, 5, 0, 0);
    pushExp("after_write", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    applyStimulus(1, 1, 7, 32'hCAFEF00D, 5, 7, 0, 0);
    pushExp("bypass_rt", 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 0, 0, 0);

    // Zero register before, during and after a write.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);           pushExp("r0_before", 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 32'h12345678, 0, 0, 0, 0); pushExp("r0_during", 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);           pushExp("r0_after", 0, 0, 0, 0, 0, 0);

    // Preload rN = 3N, reading each through the bypass as it is written.
    for (int n = 0; n < DEPTH; n++) begin
      applyStimulus(1, 1, 5'(n), 32'(n * 3), 5'(n), 5'(n), 0, 0);
      pushExp("preload", 32'(n * 3), 32'(n * 3),
              (n == 5) ? 32'hDEADBEEF : (n == 7) ? 32'hCAFEF00D : 32'd0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 5, 31, 0, 0); pushExp("preload_chk", 15, 93, 15, 0, 0, 0);

    // Full dump with ready held high.
    for (int j = 0; j < DEPTH; j++) pushDump(j, 32'(j * 3));
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1); pushExp("dump1_start", 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < DEPTH; j++) begin
      applyStimulus(1, 0, 0, 0, 5'(j), 0, 0, 1);
      pushExp("dump1_word", 32'(j * 3), 0, 32'(j * 3), 1, 5'(j), 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1); pushExp("dump1_done", 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1); pushExp("dump1_idle", 0, 0, 0, 0, 0, 0);

    // Backpressure with a write to the stalled entry, start ignored while busy.
    pushDump(0, 0); pushDump(1, 32'h0000AAAA); pushDump(2, 6);
    for (int j = 3; j < DEPTH; j++) pushDump(j, 32'(j * 3));
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);              pushExp("dump2_start", 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);              pushExp("dump2_w0", 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 1, 32'h0000AAAA, 0, 0, 1, 0);   pushExp("dump2_stall1", 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);              pushExp("dump2_stall2", 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);              pushExp("dump2_accept1", 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 1, 2, 32'h00005555, 0, 0, 0, 1);   pushExp("dump2_wr_hs", 0, 0, 0, 1, 2, 0);
    for (int j = 3; j < DEPTH; j++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
      pushExp("dump2_word", 0, 0, 0, 1, 5'(j), 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1); pushExp("dump2_done", 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1); pushExp("dump2_idle", 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a dump at ptr=10.
    for (int j = 0; j < 10; j++)
      pushDump(j, (j == 1) ? 32'h0000AAAA : (j == 2) ? 32'h00005555 : 32'(j * 3));
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1); pushExp("dump3_start", 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
      pushExp("dump3_word", 0, 0, 0, 1, 5'(j), 0);
    end
    applyStimulus(1, 0, 0, 0, 1, 2, 0, 0); pushExp("dump3_ptr10", 32'h0000AAAA, 32'h00005555, 32'h0000AAAA, 1, 10, 0);
    applyStimulus(0, 0, 0, 0, 1, 2, 0, 1); pushExp("midreset", 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 3, 31, 1, 1); pushExp("midreset_start", 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < DEPTH; i += 4) begin
      applyStimulus(1, 0, 0, 0, 5'(i), 5'(i + 1), 0, 0);
      pushExp("post_reset_read", 0, 0, 0, 0, 0, 0);
    end

    // Restarted dump begins at address 0 with all-zero contents.
    for (int j = 0; j < DEPTH; j++) pushDump(j, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1); pushExp("dump4_start", 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < DEPTH; j++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
      pushExp("dump4_word", 0, 0, 0, 1, 5'(j), 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1); pushExp("dump4_done", 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); pushExp("dump4_idle", 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1 sample_req = 1'b0;
    repeat (2) @(posedge clk);
    checkOutput("read_q_left", 32'(read_q.size()), 0);
    checkOutput("dump_q_left", 32'(dump_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised general-purpose register file for the pipelined MIPS datapath: two combinational read ports for decode, one synchronous write port for write-back, and a same-cycle write-to-read bypass that removes the need for a split-edge read. A serial dump port with a valid/ready handshake streams every entry, one per handshake, to the debug unit. It does not interfere with normal pipeline reads and writes.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are dropped
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to that read port
- clk  in  1  clock; all state changes on the rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_wenable  in  1  write enable
- i_addr_wr  in  ADDR_W  write address
- i_data_wr  in  DATA_W  write data
- i_addr_rs  in  ADDR_W  read port A address
- i_addr_rt  in  ADDR_W  read port B address
- o_data_rs  out  DATA_W  read port A data, combinational
- o_data_rt  out  DATA_W  read port B data, combinational
- i_dump_start  in  1  request a full dump; sampled only in IDLE
- i_dump_ready  in  1  consumer accepts the current dump word
- o_dump_valid  out  1  dump word present
- o_dump_addr  out  ADDR_W  index of the current dump word
- o_dump_data  out  DATA_W  contents of entry o_dump_addr
- o_dump_done  out  1  one-cycle pulse after the last word is accepted

## Operation
- Storage: DEPTH x DATA_W flops. All entries clear to 0 while i_reset_n is low.
- Write: on a rising edge with i_wenable=1, entry i_addr_wr takes i_data_wr. If ZERO_REG=1 and i_addr_wr=0, the write is dropped.
- Read: each read port returns the stored entry. With ZERO_REG=1, address 0 returns 0.
- Bypass (BYPASS=1): if i_wenable=1, the read address equals i_addr_wr, and that address is not a dropped zero-register write, the port returns i_data_wr. Both ports bypass independently. With BYPASS=0 the port returns the old stored value until the write edge.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE: o_dump_valid=0, o_dump_done=0, o_dump_addr=0, o_dump_data=0. If i_dump_start=1 at an edge, ptr is set to 0 and the FSM moves to DUMP.
  - DUMP: o_dump_valid=1, o_dump_addr=ptr, o_dump_data=stored[ptr]. The dump path takes no bypass. With ZERO_REG=1, entry 0 dumps as 0.
  - DUMP handshake: when o_dump_valid and i_dump_ready are both 1 at an edge, ptr increments. If ptr was DEPTH-1, the FSM moves to DONE instead. ptr never wraps.
  - DONE: o_dump_done=1 for exactly one cycle, then IDLE.
- i_dump_start is ignored in DUMP and DONE.
- Pipeline writes continue during a dump. A word not yet accepted reflects writes made before its handshake edge.
- Reset in any state forces IDLE, ptr=0, and all dump outputs to 0.

## Timing
- Write latency: a write is visible through the array one cycle after its edge. Through bypass it is visible in the same cycle.
- Read latency: 0 cycles (combinational from address).
- Dump start: with i_dump_start high at edge k, o_dump_valid rises after edge k.
- Dump duration: with i_dump_ready held high, valid stays high for DEPTH cycles. o_dump_done is high for the cycle after the final handshake edge, so a full dump takes DEPTH+1 cycles from start to done.
- Backpressure: with i_dump_ready low, o_dump_addr is held stable. o_dump_data follows stored[ptr], including any write to that entry.
- Write and handshake on the same entry in the same cycle: the accepted word is the pre-write value.
- Simultaneous i_dump_start and i_reset_n low: reset wins.

## Test plan
- Reset, then read every address on both ports -> all return 0. Dump outputs are 0 and the FSM is in IDLE.
- Write 0xDEADBEEF to r5 with i_addr_rs=5 in the same cycle -> o_data_rs=0xDEADBEEF in that cycle (BYPASS=1). With BYPASS=0, 0 in that cycle and 0xDEADBEEF in the next.
- Write 0x12345678 to r0 and read r0 on both ports -> 0 before, during and after the write. A dump word at index 0 is also 0.
- Preload rN=N*3, pulse start, hold ready=1 -> 32 words with addr 0..31 and data 0,3,...,93 on consecutive cycles. o_dump_done is high for one cycle after word 31, then IDLE.
- Dump with ready toggling 1,0,0,1 while writing 0xAAAA to the currently presented entry during a stall -> addr holds during stall cycles and the accepted data is 0xAAAA. i_dump_start during DUMP has no effect.
- Assert i_reset_n=0 mid-dump at ptr=10 -> valid drops immediately, all entries read 0, and a new start restarts the dump at addr 0.
